reg_wr_arbiter: RTL and testbench

- Shares the register file's single write port among NUM_REQ writeback requesters, for example the ALU writeback, the load unit and the debug loader.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file's wr_en, w_addr and w_data from registered outputs.
- Can optionally sequence a zero-clear of every register after reset.

---
 rtl/reg_wr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_reg_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing a single register-file write port among NUM_REQ requesters.
// Define REG_WR_ARB_CLEAR_EN to zero-clear registers 1..2**ADDR_WIDTH-1 after reset.
module reg_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          w_addr,
  output logic [DATA_WIDTH-1:0]          w_data,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           init_busy
);

  localparam int unsigned GNT_W = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = GNT_W + 1;
  localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [GNT_W-1:0]      grant_q, grant_d;
  logic [GNT_W-1:0]      ptr_q, ptr_d;

  logic                  run_c;
  logic                  found_c;
  logic                  accept_c;
  logic [GNT_W-1:0]      gnt_idx_c;
  logic [SUM_W-1:0]      sum_c;
  logic [SUM_W-1:0]      gnt_inc_c;

  // Unpack requester slices
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef REG_WR_ARB_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clear_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= ADDR_WIDTH'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Walk the counter through every non-zero address, then hand over to RUN
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  assign clear_c   = (state_q == ST_CLEAR);
  assign run_c     = (state_q == ST_RUN);
  assign init_busy = clear_c;
`else
  assign run_c     = 1'b1;
  assign init_busy = 1'b0;
`endif

  // Search ptr, ptr+1, ... modulo NUM_REQ for the first valid requester
  always_comb begin
    found_c   = 1'b0;
    gnt_idx_c = '0;
    sum_c     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum_c = SUM_W'(ptr_q) + SUM_W'(k);
      if (sum_c >= NUM_REQ_S) begin
        sum_c = sum_c - NUM_REQ_S;
      end
      if (!found_c && req_valid[sum_c[GNT_W-1:0]]) begin
        found_c   = 1'b1;
        gnt_idx_c = sum_c[GNT_W-1:0];
      end
    end
    accept_c = found_c && run_c;
  end

  always_comb begin
    req_ready = '0;
    if (accept_c) begin
      req_ready[gnt_idx_c] = 1'b1;
    end
  end

  // Next values of the write port, grant index and round-robin pointer
  always_comb begin
    wr_en_d   = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    gnt_inc_c = SUM_W'(gnt_idx_c) + SUM_W'(1);
`ifdef REG_WR_ARB_CLEAR_EN
    if (clear_c) begin
      wr_en_d  = 1'b1;
      w_addr_d = clr_cnt_q;
      w_data_d = '0;
    end else
`endif
    if (accept_c) begin
      // r0 writes are consumed but never reach the register file
      wr_en_d  = (addr_a[gnt_idx_c] != '0);
      w_addr_d = addr_a[gnt_idx_c];
      w_data_d = data_a[gnt_idx_c];
      grant_d  = gnt_idx_c;
      ptr_d    = (gnt_inc_c == NUM_REQ_S) ? '0 : gnt_inc_c[GNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed self-checking bench for reg_wr_arbiter (3 requesters, 32-bit data, 5-bit address).
// Clear-sequence checks are included when REG_WR_ARB_CLEAR_EN is defined.
module tb_reg_wr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;
  localparam int unsigned GW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [AW-1:0] a [NR];
  logic [DW-1:0] d [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [GW-1:0] grant_id;
  logic          init_busy;

  int n_checks = 0;
  int n_errors = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  reg_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .init_busy (init_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    a[i] = ad;
    d[i] = dt;
  endtask

  // Assert reset (async), check reset values, release and wait out any clear
  task automatic do_reset();
    int n;
    req_valid = '0;
    reset = 1'b1;
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_w_addr", w_addr, '0);
    check("rst_w_data", w_data, '0);
    check("rst_grant", grant_id, '0);
    check("rst_ready", req_ready, '0);
`ifdef REG_WR_ARB_CLEAR_EN
    check("rst_busy", init_busy, 1'b1);
`else
    check("rst_busy", init_busy, 1'b0);
`endif
    tick();
    tick();
    reset = 1'b0;
    n = 0;
`ifdef REG_WR_ARB_CLEAR_EN
    while (init_busy && n < 40) begin
      tick();
      n++;
    end
    check("clear_len", 64'(n), 64'd31);
`endif
    check("busy_after_rst", init_busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] exp_rdy;
    int            g;
    reset     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 3; i++) set_req(i, '0, '0);
    #2;
    do_reset();

`ifdef REG_WR_ARB_CLEAR_EN
    // Clear with a pending request that must wait until RUN
    reset = 1'b1;
    set_req(0, 5'd7, 32'h77);
    req_valid = 3'b001;
    tick();
    check("clr_rst_wr_en", wr_en, 1'b0);
    check("clr_rst_ready", req_ready, '0);
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      check("clr_busy", init_busy, 1'b1);
      check("clr_ready", req_ready, '0);
      tick();
      check("clr_wr_en", wr_en, 1'b1);
      check("clr_w_addr", w_addr, 64'(i));
      check("clr_w_data", w_data, '0);
    end
    check("clr_end_busy", init_busy, 1'b0);
    check("clr_end_ready", req_ready, 3'b001);
    tick();
    check("pend_wr_en", wr_en, 1'b1);
    check("pend_w_addr", w_addr, 5'd7);
    check("pend_w_data", w_data, 32'h77);
    check("pend_grant", grant_id, 2'd0);
    req_valid = '0;

    // Abort the clear at address 12 and confirm it restarts at 1
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) tick();
    check("abort_pre_addr", w_addr, 5'd12);
    reset = 1'b1;
    #1;
    check("abort_wr_en", wr_en, 1'b0);
    check("abort_w_addr", w_addr, '0);
    tick();
    check("abort_hold_wr_en", wr_en, 1'b0);
    reset = 1'b0;
    tick();
    check("restart_wr_en", wr_en, 1'b1);
    check("restart_w_addr", w_addr, 5'd1);
    do_reset();
`endif

    // Single request from requester 1
    set_req(1, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    check("t1_ready", req_ready, 3'b010);
    tick();
    check("t1_wr_en", wr_en, 1'b1);
    check("t1_w_addr", w_addr, 5'd5);
    check("t1_w_data", w_data, 32'hDEADBEEF);
    check("t1_grant", grant_id, 2'd1);
    req_valid = '0;
    tick();
    check("t1_wr_en_off", wr_en, 1'b0);
    check("t1_addr_hold", w_addr, 5'd5);

    // All requesters valid: strict rotation from ptr 0
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      exp_rdy = NR'(1) << g;
      #1;
      check("rr_ready", req_ready, exp_rdy);
      tick();
      check("rr_wr_en", wr_en, 1'b1);
      check("rr_grant", grant_id, 64'(g));
      check("rr_w_addr", w_addr, 64'(g + 1));
      check("rr_w_data", w_data, 64'(32'hA0 + g));
    end

    // Reset right after a write aborts it
    do_reset();

    // Write to r0 is consumed but dropped
    set_req(0, 5'd0, 32'h1234);
    req_valid = 3'b001;
    #1;
    check("r0_ready", req_ready, 3'b001);
    tick();
    check("r0_wr_en", wr_en, 1'b0);
    check("r0_grant", grant_id, 2'd0);
    check("r0_w_data", w_data, 32'h1234);
    req_valid = '0;

    // ptr is now 1: requester 2 wins over 0, then 0 follows
    set_req(0, 5'd9, 32'hAAAA);
    set_req(2, 5'd10, 32'hBBBB);
    req_valid = 3'b101;
    #1;
    check("p1_ready_a", req_ready, 3'b100);
    tick();
    check("p1_grant_a", grant_id, 2'd2);
    check("p1_w_addr_a", w_addr, 5'd10);
    check("p1_wr_en_a", wr_en, 1'b1);
    req_valid = 3'b001;
    #1;
    check("p1_ready_b", req_ready, 3'b001);
    tick();
    check("p1_grant_b", grant_id, 2'd0);
    check("p1_w_addr_b", w_addr, 5'd9);
    check("p1_w_data_b", w_data, 32'hAAAA);
    req_valid = '0;

    // Lone requester 2 is accepted every cycle, across the pointer wrap
    set_req(2, 5'd31, 32'h5);
    req_valid = 3'b100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("solo_ready", req_ready, 3'b100);
      tick();
      check("solo_wr_en", wr_en, 1'b1);
      check("solo_grant", grant_id, 2'd2);
      check("solo_w_addr", w_addr, 5'd31);
    end
    req_valid = '0;

    // Idle cycle holds port values and drops wr_en
    tick();
    check("idle_wr_en", wr_en, 1'b0);
    check("idle_grant", grant_id, 2'd2);
    check("idle_w_addr", w_addr, 5'd31);
    check("idle_w_data", w_data, 32'h5);
    check("idle_ready", req_ready, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
